// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad number-entry block: the scanner
// FSM state encoding, the special key codes, the entry limits, and the
// row/column to key-code map.
// No ports (package).
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } scan_state_e;

  localparam logic [3:0]  KEY_BKSP   = 4'd13;
  localparam logic [3:0]  KEY_CLEAR  = 4'd14;
  localparam logic [3:0]  KEY_ENTER  = 4'd15;
  localparam logic [3:0]  KEY_MAX_DIGIT = 4'd9;
  localparam logic [12:0] MAX_NUM    = 13'd8191;
  localparam logic [2:0]  MAX_DIGITS = 3'd4;

  // Physical layout:
  //   row0: 1 2 3 A
  //   row1: 4 5 6 B
  //   row2: 7 8 9 C
  //   row3: * 0 # D
  function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = 4'd10;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = 4'd11;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = 4'd12;
      4'b11_00: code = KEY_CLEAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_ENTER;
      4'b11_11: code = KEY_BKSP;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Drives the keypad columns one at a time, samples the synchronized rows,
// debounces a press, emits a single key event per press and waits for a
// debounced release before moving on.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_SCAN     | column col_q driven low, rows sampled on last scan clock
// ST_DEBOUNCE | captured row must stay low DEBOUNCE_CYCLES clocks -> event
// ST_RELEASE  | captured row must stay high DEBOUNCE_CYCLES clocks -> next col
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   row_i[3:0] in   raw keypad rows, active-low, asynchronous
//   col_o[3:0] out  column drive, one-hot active-low
//   key_evt_o  out  one-cycle accepted-key pulse
//   key_code_o out  code of the key under the captured row/column
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       key_evt_o,
  output logic [3:0] key_code_o
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_s1_q, row_s2_q;
  scan_state_e   state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          any_low;
  logic [1:0]    low_idx;
  logic          cap_high;

  assign any_low  = ~&row_s2_q;
  assign cap_high = row_s2_q[row_q];

  // Lowest-index low row wins when several rows read low.
  always_comb begin
    if (!row_s2_q[0])      low_idx = 2'd0;
    else if (!row_s2_q[1]) low_idx = 2'd1;
    else if (!row_s2_q[2]) low_idx = 2'd2;
    else                   low_idx = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
      state_q  <= ST_SCAN;
      col_q    <= 2'd0;
      row_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (any_low) begin
            row_d   = low_idx;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (cap_high) begin
          // Bounce: rescan the same column from the start.
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!cap_high) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    col_o      = ~(4'b0001 << col_q);
    key_evt_o  = (state_q == ST_DEBOUNCE) && !cap_high && (cnt_q == DEB_LAST);
    key_code_o = key_code_f(row_q, col_q);
  end

endmodule

// File: rtl/keypad_num_entry.sv
// keypad_num_entry
// Top level: 4x4 keypad decimal number entry. The scanner produces debounced
// key events; this module accumulates up to four digits into a value no
// larger than 8191, with Clear (*) and Enter (#).
//
// Build option: KEYPAD_BACKSPACE_EN -- when defined, key D removes the last
// digit; otherwise D only updates key_code like A-C.
//
// Ports:
//   clk              in   clock
//   rst              in   asynchronous active-high reset
//   Row[3:0]         in   keypad rows, active-low, asynchronous
//   Col[3:0]         out  keypad column drive, one-hot active-low
//   num[12:0]        out  entered value
//   digit_count[2:0] out  digits in num (0..4)
//   num_valid        out  one-cycle pulse after Enter
//   key_code[3:0]    out  last accepted key code
module keypad_num_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Row,
  output logic [3:0]  Col,
  output logic [12:0] num,
  output logic [2:0]  digit_count,
  output logic        num_valid,
  output logic [3:0]  key_code
);

  logic        key_evt;
  logic [3:0]  evt_code;

  logic [12:0] num_q, num_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [3:0]  code_q, code_d;
  logic        restart_q, restart_d;

  logic [12:0] base_num;
  logic [2:0]  base_cnt;
  logic [13:0] append_w;

  keypad_scanner #(
    .SCAN_CYCLES     (SCAN_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .row_i      (Row),
    .col_o      (Col),
    .key_evt_o  (key_evt),
    .key_code_o (evt_code)
  );

  // After Enter the displayed value is kept until the next digit, which
  // starts a fresh number.
  assign base_num = restart_q ? 13'd0 : num_q;
  assign base_cnt = restart_q ? 3'd0  : cnt_q;
  assign append_w = {1'b0, base_num} * 14'd10 + {10'd0, evt_code};

  always_comb begin
    num_d     = num_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    restart_d = restart_q;
    if (key_evt) begin
      code_d = evt_code;
      if (evt_code <= KEY_MAX_DIGIT) begin
        if ((base_cnt < MAX_DIGITS) && (append_w <= {1'b0, MAX_NUM})) begin
          num_d     = append_w[12:0];
          cnt_d     = base_cnt + 3'd1;
          restart_d = 1'b0;
        end
      end else if (evt_code == KEY_CLEAR) begin
        num_d     = 13'd0;
        cnt_d     = 3'd0;
        restart_d = 1'b0;
      end else if (evt_code == KEY_ENTER) begin
        valid_d   = 1'b1;
        restart_d = 1'b1;
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if (evt_code == KEY_BKSP) begin
        if (cnt_q != 3'd0) begin
          num_d = num_q / 13'd10;
          cnt_d = cnt_q - 3'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q     <= 13'd0;
      cnt_q     <= 3'd0;
      valid_q   <= 1'b0;
      code_q    <= 4'd0;
      restart_q <= 1'b0;
    end else begin
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      restart_q <= restart_d;
    end
  end

  assign num         = num_q;
  assign digit_count = cnt_q;
  assign num_valid   = valid_q;
  assign key_code    = code_q;

endmodule

// File: tb/tb_keypad_num_entry.sv
// tb_keypad_num_entry
// Scoreboard bench for keypad_num_entry with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
// A keypad model pulls the pressed key's row low while its column is driven.
module tb_keypad_num_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [12:0] num;
  logic [2:0]  digit_count;
  logic        num_valid;
  logic [3:0]  key_code;

  logic        key_down;
  logic [1:0]  key_r, key_c;

  int n_checks = 0;
  int n_errors = 0;
  int nv_seen  = 0;

  typedef struct {
    int num;
    int cnt;
    int code;
    int nv;
  } exp_t;
  exp_t sb_q[$];

  int m_num, m_cnt, m_code, m_nv;
  bit m_restart;

  keypad_num_entry #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Row         (Row),
    .Col         (Col),
    .num         (num),
    .digit_count (digit_count),
    .num_valid   (num_valid),
    .key_code    (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    Row = 4'b1111;
    if (key_down && (Col[key_c] == 1'b0)) Row[key_r] = 1'b0;
  end

  always @(negedge clk) if (num_valid) nv_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input int code);
    case (code)
      1: return 0;   2: return 1;   3: return 2;   10: return 3;
      4: return 4;   5: return 5;   6: return 6;   11: return 7;
      7: return 8;   8: return 9;   9: return 10;  12: return 11;
      14: return 12; 0: return 13;  15: return 14; 13: return 15;
      default: return 0;
    endcase
  endfunction

  task automatic model_key(input int code);
    exp_t e;
    int bn, bc;
    bn = m_restart ? 0 : m_num;
    bc = m_restart ? 0 : m_cnt;
    if (code <= 9) begin
      if (bc < 4 && (bn * 10 + code) <= 8191) begin
        m_num = bn * 10 + code;
        m_cnt = bc + 1;
        m_restart = 0;
      end
    end else if (code == 14) begin
      m_num = 0; m_cnt = 0; m_restart = 0;
    end else if (code == 15) begin
      m_nv++; m_restart = 1;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (code == 13) begin
      if (m_cnt != 0) begin
        m_num = m_num / 10;
        m_cnt = m_cnt - 1;
      end
    end
`endif
    m_code = code;
    e.num = m_num; e.cnt = m_cnt; e.code = m_code; e.nv = m_nv;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_num"}, int'(num), e.num);
      check({tag, "_cnt"}, int'(digit_count), e.cnt);
      check({tag, "_code"}, int'(key_code), e.code);
      check({tag, "_nv"}, nv_seen, e.nv);
    end
  endtask

  task automatic press(input int code, input int hold);
    int p;
    p = pos_of(code);
    model_key(code);
    @(negedge clk);
    key_r = 2'(p / 4);
    key_c = 2'(p % 4);
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
    sb_compare($sformatf("key%0d", code));
  endtask

  // Waits until the column drive has just switched to target; returns 0 on timeout.
  task automatic wait_col_enter(input logic [3:0] target, output bit found);
    logic [3:0] prev;
    found = 0;
    prev = Col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (Col == target && prev != target) found = 1;
      else prev = Col;
    end
  endtask

  initial begin
    bit found;
    int bad;
    int saved_num, saved_code, saved_nv;

    key_down = 1'b0; key_r = 2'd0; key_c = 2'd0;
    m_num = 0; m_cnt = 0; m_code = 0; m_nv = 0; m_restart = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", int'(Col), 4'b1110);
    check("rst_num", int'(num), 0);
    check("rst_cnt", int'(digit_count), 0);
    check("rst_valid", int'(num_valid), 0);
    check("rst_code", int'(key_code), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1,2,3,# -> 123 with one Enter pulse
    press(1, 60); press(2, 60); press(3, 60); press(15, 60);

    // Overflow rejection, then the largest legal value and the digit limit
    press(8, 60); press(1, 60); press(9, 60); press(2, 60);
    press(14, 60);
    press(8, 60); press(1, 60); press(9, 60); press(1, 60);
    press(5, 60);

    // Bounce on column 2: short press must not produce an event
    saved_num = int'(num); saved_code = int'(key_code);
    wait_col_enter(4'b1011, found);
    check("bounce_col_found", int'(found), 1);
    key_r = 2'd0; key_c = 2'd2; key_down = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    key_down = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bounce_same_col", int'(Col), 4'b1011);
    @(posedge clk);
    @(negedge clk);
    check("bounce_next_col", int'(Col), 4'b0111);
    repeat (30) @(negedge clk);
    check("bounce_num", int'(num), saved_num);
    check("bounce_code", int'(key_code), saved_code);

    // Hold 5 for 100 clocks: one append, column frozen through release debounce
    press(14, 60);
    model_key(5);
    @(negedge clk);
    key_r = 2'd1; key_c = 2'd1; key_down = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i >= 40 && Col != 4'b1101) bad++;
    end
    check("hold_col_frozen", bad, 0);
    key_down = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Col != 4'b1101) bad++;
    end
    check("release_col_frozen", bad, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (Col != 4'b1101) found = 1;
    end
    check("release_col_advance", int'(Col), 4'b1011);
    repeat (20) @(negedge clk);
    sb_compare("hold5");

    // Backspace (or plain code with the option off), then Clear, then A
    press(14, 60);
    press(4, 60); press(2, 60); press(13, 60);
    press(14, 60);
    press(6, 60); press(10, 60);

    // Reset during debounce discards the key
    saved_nv = nv_seen;
    wait_col_enter(4'b1110, found);
    check("rst_col_found", int'(found), 1);
    key_r = 2'd1; key_c = 2'd0; key_down = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    key_down = 1'b0;
    @(negedge clk);
    check("mid_rst_col", int'(Col), 4'b1110);
    check("mid_rst_num", int'(num), 0);
    check("mid_rst_cnt", int'(digit_count), 0);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_valid", int'(num_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_num", int'(num), 0);
    check("post_rst_code", int'(key_code), 0);
    check("post_rst_cnt", int'(digit_count), 0);
    check("post_rst_nv", nv_seen, saved_nv);
    m_num = 0; m_cnt = 0; m_code = 0; m_restart = 0;

    // Fresh entry after reset, then Enter followed by a digit restarts the number
    press(7, 60); press(15, 60); press(3, 60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
